ivs_dma_rd_arb: RTL and testbench

- Parametrised N-channel AXI read-DMA front end. Successor to the fixed three-port read interface; sits between the IVS DMA channel engines and the AXI read bus.
- Arbitrates channel read requests round-robin and issues one AR burst per grant, with arid = channel index.
- Tracks one outstanding burst per channel and routes R beats back by rid.
- Flags per-channel response errors and stray IDs.

---
 rtl/ivs_dma_pkg.sv | 20 ++
 rtl/ivs_rr_arb.sv | 37 +++
 rtl/ivs_dma_rd_arb.sv | 150 +++++++++++++++
 tb/tb_ivs_dma_rd_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ivs_dma_pkg.sv
// Shared constants, AR state encoding and a width helper for the IVS read-DMA front end.
package ivs_dma_pkg;

  localparam int         BDWD           = 128;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_VALID = 1'b1
  } ar_state_e;

  function automatic int clog2(input int value);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= value) return r;
    end
    return 31;
  endfunction

endpackage

// File: rtl/ivs_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module ivs_rr_arb
  import ivs_dma_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so one subtraction is enough to wrap
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ivs_dma_rd_arb.sv
// N-channel AXI read-DMA front end: round-robin AR issue, one burst in flight per
// channel, R beats steered to channels by rid.
module ivs_dma_rd_arb
  import ivs_dma_pkg::*;
#(
  parameter int NCH = 3,
  parameter int AW  = 32,
  parameter int DW  = BDWD,
  parameter int IDW = 4,
  parameter int LW  = 6
) (
  input  logic              aclk,
  input  logic              arst_n,
  output logic              arvalid,
  input  logic              arready,
  output logic [IDW-1:0]    arid,
  output logic [AW-1:0]     araddr,
  output logic [LW-1:0]     arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic [3:0]        arregion,
  output logic [3:0]        arqos,
  output logic [7:0]        aruser,
  input  logic              rvalid,
  output logic              rready,
  input  logic [IDW-1:0]    rid,
  input  logic [DW-1:0]     rdata,
  input  logic              rlast,
  input  logic [1:0]        rresp,
  input  logic [NCH-1:0]    dr_req,
  input  logic [NCH*AW-1:0] dr_base,
  input  logic [NCH*LW-1:0] dr_len,
  output logic [NCH-1:0]    dr_ack,
  output logic [DW-1:0]     dr_rdata,
  output logic [NCH-1:0]    dr_valid,
  output logic [NCH-1:0]    dr_last,
  output logic [NCH-1:0]    dr_err,
  output logic              bad_id
);

  localparam int PW = (NCH > 1) ? clog2(NCH) : 1;

  ar_state_e      state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] dr_err_q, dr_err_d;
  logic [AW-1:0]  araddr_q, araddr_d;
  logic [LW-1:0]  arlen_q, arlen_d;
  logic [IDW-1:0] arid_q, arid_d;

  logic [NCH-1:0] cand;
  logic [NCH-1:0] grant;
  logic [PW-1:0]  gidx;
  logic           ar_hs;
  logic [NCH-1:0] beat_err;

  assign cand  = dr_req & ~busy_q;
  assign ar_hs = (state_q == AR_VALID) && arready;

  ivs_rr_arb #(
    .N  (NCH),
    .PW (PW)
  ) u_rr_arb (
    .req   (cand),
    .ptr   (ptr_q),
    .grant (grant),
    .gidx  (gidx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign dr_ack[gi]   = ar_hs && (arid_q == IDW'(gi));
      assign dr_valid[gi] = rvalid && (rid == IDW'(gi));
      assign dr_last[gi]  = dr_valid[gi] && rlast;
      assign beat_err[gi] = dr_valid[gi] && (rresp != AXI_RESP_OKAY);
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    case (state_q)
      AR_IDLE: begin
        if (|grant) begin
          araddr_d = dr_base[gidx*AW +: AW];
          arlen_d  = dr_len[gidx*LW +: LW];
          arid_d   = IDW'(gidx);
          state_d  = AR_VALID;
        end
      end
      AR_VALID: begin
        if (arready) begin
          ptr_d   = (arid_q == IDW'(NCH-1)) ? '0 : PW'(arid_q + 1'b1);
          state_d = AR_IDLE;
        end
      end
      default: state_d = AR_IDLE;
    endcase
  end

  // A new grant sets busy; a stray rlast on an idle channel leaves it clear.
  assign busy_d   = (busy_q & ~dr_last) | dr_ack;
  assign dr_err_d = (dr_err_q & ~dr_ack) | beat_err;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= AR_IDLE;
      ptr_q    <= '0;
      busy_q   <= '0;
      dr_err_q <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      dr_err_q <= dr_err_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arid_q   <= arid_d;
    end
  end

  assign arvalid  = (state_q == AR_VALID);
  assign arid     = arid_q;
  assign araddr   = araddr_q;
  assign arlen    = arlen_q;
  assign arsize   = 3'(clog2(DW/8));
  assign arburst  = AXI_BURST_INCR;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arregion = 4'd0;
  assign arqos    = 4'd0;
  assign aruser   = 8'd0;

  assign rready   = 1'b1;
  assign dr_rdata = rdata;
  assign dr_err   = dr_err_q;
  assign bad_id   = rvalid && ({1'b0, rid} >= (IDW+1)'(NCH));

endmodule

// File: tb/tb_ivs_dma_rd_arb.sv
// Directed bench for ivs_dma_rd_arb: expected AR bursts queued at request time,
// popped and compared at each AR handshake.
module tb_ivs_dma_rd_arb;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [5:0]  len;
  } ar_t;

  logic         aclk, arst_n;
  logic         arvalid, arready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [5:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic [3:0]   arregion;
  logic [3:0]   arqos;
  logic [7:0]   aruser;
  logic         rvalid, rready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic         rlast;
  logic [1:0]   rresp;
  logic [2:0]   dr_req;
  logic [95:0]  dr_base;
  logic [17:0]  dr_len;
  logic [2:0]   dr_ack;
  logic [127:0] dr_rdata;
  logic [2:0]   dr_valid, dr_last, dr_err;
  logic         bad_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  ar_t exp_q[$];
  logic [31:0] base_a[3];
  logic [5:0]  len_a[3];

  ivs_dma_rd_arb dut (
    .aclk(aclk), .arst_n(arst_n),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arregion(arregion), .arqos(arqos),
    .aruser(aruser), .rvalid(rvalid), .rready(rready), .rid(rid),
    .rdata(rdata), .rlast(rlast), .rresp(rresp), .dr_req(dr_req),
    .dr_base(dr_base), .dr_len(dr_len), .dr_ack(dr_ack), .dr_rdata(dr_rdata),
    .dr_valid(dr_valid), .dr_last(dr_last), .dr_err(dr_err), .bad_id(bad_id)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) if (|dr_ack) ack_cnt <= ack_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [31:0] base, input logic [5:0] len);
    base_a[i] = base;
    len_a[i]  = len;
    dr_base[i*32 +: 32] = base;
    dr_len[i*6 +: 6]    = len;
  endtask

  task automatic push_ar(input int i);
    ar_t e;
    e.id   = 4'(i);
    e.addr = base_a[i];
    e.len  = len_a[i];
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for an AR handshake and checks it against the queue head.
  task automatic wait_ar(input string tag, output int waited);
    ar_t  e;
    logic hs;
    #1;
    waited = 0;
    while (!(arvalid && arready) && waited < 50) begin
      tick();
      #1;
      waited++;
    end
    hs = arvalid && arready;
    chk({tag, "_handshake"}, hs, 1'b1);
    if (hs) begin
      chk({tag, "_queue"}, (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_arid"}, arid, e.id);
        chk({tag, "_araddr"}, araddr, e.addr);
        chk({tag, "_arlen"}, arlen, e.len);
        chk({tag, "_dr_ack"}, dr_ack, 3'b001 << e.id);
        $display("AR %s: arid=%0d araddr=%08h arlen=%0d cyc=%0d", tag, arid, araddr, arlen, cyc);
      end
    end
  endtask

  task automatic r_beat(input logic [3:0] id, input logic last, input logic [1:0] resp);
    logic [127:0] data;
    logic [2:0]   exp_v;
    data   = {$urandom, $urandom, $urandom, $urandom};
    rvalid = 1'b1; rid = id; rlast = last; rresp = resp; rdata = data;
    #1;
    exp_v = (id < 4'd3) ? (3'b001 << id) : 3'b000;
    chk("r_dr_valid", dr_valid, exp_v);
    chk("r_dr_last", dr_last, last ? exp_v : 3'b000);
    chk("r_bad_id", bad_id, (id >= 4'd3));
    chk("r_dr_rdata", dr_rdata, data);
    $display("R beat: rid=%0d rlast=%0d rresp=%0d dr_valid=%b dr_last=%b bad_id=%0d",
             id, last, resp, dr_valid, dr_last, bad_id);
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  // All channels request continuously; each burst returns one beat right away.
  task automatic rr_run(input int n, input string tag);
    int w, prev;
    prev   = 0;
    dr_req = 3'b111;
    for (int i = 0; i < n; i++) begin
      push_ar(i % 3);
      if (i == 0) tick();
      wait_ar(tag, w);
      if (i > 0) chk({tag, "_spacing"}, 128'(cyc - prev), 128'd2);
      prev = cyc;
      tick();
      if (i == n - 1) dr_req = 3'b000;
      r_beat(4'(i % 3), 1'b1, 2'b00);
    end
  endtask

  initial begin
    int w, ack0;
    arst_n = 1'b0; arready = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0;
    rlast = 1'b0; rresp = 2'b00; dr_req = '0; dr_base = '0; dr_len = '0;
    for (int i = 0; i < 3; i++) set_ch(i, 32'h2000_0000 + 32'(i) * 32'h100, 6'(i + 1));

    // Reset state
    #2;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arid", arid, 4'h0);
    chk("rst_arlen", arlen, 6'h0);
    chk("rst_dr_ack", dr_ack, 3'b000);
    chk("rst_dr_err", dr_err, 3'b000);
    chk("const_arsize", arsize, 3'd4);
    chk("const_arburst", arburst, 2'b01);
    chk("const_rready", rready, 1'b1);
    #20 arst_n = 1'b1;
    tick();

    // Single request on channel 1, then an 8-beat burst
    set_ch(1, 32'h1000_0040, 6'd7);
    dr_req = 3'b010;
    push_ar(1);
    tick();
    wait_ar("single", w);
    chk("single_latency", w, 0);
    tick();
    dr_req = 3'b000;
    for (int b = 0; b < 8; b++) r_beat(4'd1, (b == 7), 2'b00);

    // Backpressure on channel 2 (ptr now 2)
    set_ch(2, 32'h3000_0080, 6'd3);
    arready = 1'b0;
    dr_req  = 3'b100;
    push_ar(2);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_arvalid", arvalid, 1'b1);
      chk("bp_arid", arid, 4'd2);
      chk("bp_araddr", araddr, 32'h3000_0080);
      chk("bp_arlen", arlen, 6'd3);
      chk("bp_no_ack", dr_ack, 3'b000);
      tick();
    end
    ack0    = ack_cnt;
    arready = 1'b1;
    wait_ar("bp", w);
    tick();
    dr_req = 3'b000;
    tick();
    chk("bp_ack_once", 128'(ack_cnt - ack0), 128'd1);
    chk("bp_idle", arvalid, 1'b0);
    r_beat(4'd2, 1'b1, 2'b00);

    // Round robin from ptr 0
    for (int i = 0; i < 3; i++) set_ch(i, 32'h2000_0000 + 32'(i) * 32'h100, 6'(i + 1));
    rr_run(6, "rr");

    // One outstanding burst per channel
    set_ch(0, 32'h4000_0000, 6'd1);
    dr_req = 3'b001;
    push_ar(0);
    tick();
    wait_ar("out_ch0", w);
    dr_req = 3'b101;
    push_ar(2);
    tick();
    wait_ar("out_ch2", w);
    tick();
    dr_req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("out_blocked", arvalid, 1'b0);
      tick();
    end
    r_beat(4'd0, 1'b1, 2'b00);
    #1;
    chk("out_not_yet", arvalid, 1'b0);
    push_ar(0);
    tick();
    wait_ar("out_regrant", w);
    chk("out_regrant_latency", w, 0);
    tick();
    dr_req = 3'b000;

    // Error response and stray ID (ch0 busy)
    r_beat(4'd0, 1'b0, 2'b10);
    #1;
    chk("err_set", dr_err, 3'b001);
    r_beat(4'd0, 1'b1, 2'b00);
    #1;
    chk("err_sticky", dr_err, 3'b001);
    r_beat(4'd5, 1'b0, 2'b11);
    #1;
    chk("bad_id_pulse_end", bad_id, 1'b0);
    chk("bad_id_no_err", dr_err, 3'b001);
    dr_req = 3'b001;
    push_ar(0);
    tick();
    wait_ar("err_ack", w);
    chk("err_held_in_ack", dr_err, 3'b001);
    tick();
    dr_req = 3'b000;
    chk("err_clear", dr_err, 3'b000);
    r_beat(4'd0, 1'b1, 2'b00);

    // Async reset while an AR is pending (ch2 still busy from earlier)
    set_ch(1, 32'h5000_0000, 6'd9);
    arready = 1'b0;
    dr_req  = 3'b010;
    tick();
    #1;
    chk("rst_mid_pending", arvalid, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_mid_arvalid", arvalid, 1'b0);
    chk("rst_mid_araddr", araddr, 32'h0);
    chk("rst_mid_dr_ack", dr_ack, 3'b000);
    dr_req = 3'b000;
    tick();
    tick();
    arst_n  = 1'b1;
    arready = 1'b1;
    for (int i = 0; i < 3; i++) set_ch(i, 32'h6000_0000 + 32'(i) * 32'h40, 6'(i + 4));
    rr_run(3, "post_rst");
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
